enc_stream_arbiter: RTL and testbench
=====================================

// Module: enc_stream_arbiter
// PURPOSE
//  Shares one RS encoder datapath between NUM_CH upstream message streams.
//  Grants the encoder to one channel for a whole message (MSG_BEATS beats), with no preemption.
//  Channels are served round-robin at message granularity.
//  Sits in front of the encoder input and honours the encoder's stall (con_stall) as backpressure.
//  The output beat is registered: a one-entry pipeline register with valid/stall flow control.
// PARAMETERS
//  NUM_CH       4   number of requesting channels (>= 2)
//  ENC_SYM_NUM  8   symbols per beat
//  EGF_ORDER    8   bits per symbol
//  MSG_BEATS    28  beats per message (>= 1); W = ENC_SYM_NUM*EGF_ORDER below
// PORTS
//  clk        in   1                clock
//  rst_n      in   1                reset, synchronous, active-low
//  ch_valid   in   NUM_CH           per-channel beat valid
//  ch_ready   out  NUM_CH           per-channel beat accept
//  ch_data    in   NUM_CH*W         channel c beat at [c*W +: W]
//  enc_stall  in   1                encoder cannot take a beat this cycle
//  enc_valid  out  1                output register holds a beat
//  enc_data   out  W                beat to encoder
//  enc_sof    out  1                beat is first of message
//  enc_eof    out  1                beat is last of message
//  enc_ch     out  $clog2(NUM_CH)   source channel of beat
//  busy       out  1                state == BURST
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; rr_ptr = 0; beat_cnt = 0; output register cleared.
//   Reset mid-message drops the in-flight beat; no partial-message recovery.
//  FSM IDLE:
//   - If any ch_valid: grant g = first asserted channel scanning rr_ptr, rr_ptr+1, ... (mod NUM_CH).
//   - Register g and go to BURST; beat_cnt = 0.
//   - ch_ready is all-zero in IDLE, giving a one-cycle arbitration bubble.
//  FSM BURST:
//   - ch_ready[g] = !enc_valid || !enc_stall; all other ch_ready = 0.
//   - accept = ch_valid[g] && ch_ready[g].
//   - On accept, the output register loads, at the next edge:
//     enc_data = ch_data[g]; enc_ch = g; enc_sof = (beat_cnt == 0);
//     enc_eof = (beat_cnt == MSG_BEATS-1); enc_valid = 1. Then beat_cnt++.
//   - If enc_valid && !enc_stall with no accept: enc_valid <= 0.
//   - If enc_valid && enc_stall: all output fields hold unchanged.
//   - Accept on beat_cnt == MSG_BEATS-1: go to IDLE; beat_cnt = 0; rr_ptr = (g+1) mod NUM_CH.
//   - Granted channel dropping ch_valid mid-message keeps the grant (no timeout, no preemption);
//     no beat is produced that cycle.
//   - Other channels' ch_valid are ignored until IDLE.
//  Latency: accept to enc_valid is 1 cycle.
//  Throughput: 1 beat/cycle while !enc_stall; MSG_BEATS+1 cycles per message minimum.
//  MSG_BEATS == 1: every beat has sof = eof = 1.
//  Simultaneous requests in IDLE resolve purely by rr_ptr order; rr_ptr wraps NUM_CH-1 -> 0.
//  Invariant: beats of different messages never interleave on enc_*.
// TESTING
//  1. Single channel: ch_valid[2] held, data = beat index, MSG_BEATS=4, no stall
//     -> busy 1 cycle after request; enc_valid 4 consecutive cycles;
//        enc_sof on beat 0, enc_eof on beat 3, enc_ch = 2; rr_ptr = 3.
//  2. All 4 channels valid from reset
//     -> messages served in order ch0, ch1, ch2, ch3, ch0; one idle cycle between messages.
//  3. enc_stall high 3 cycles mid-burst with enc_valid = 1
//     -> enc_data/sof/eof/ch frozen; ch_ready[g] = 0; no beat lost or duplicated on release.
//  4. Granted ch1 drops ch_valid for 2 cycles after beat 1; ch0 valid throughout
//     -> grant stays on ch1; enc_valid low 2 cycles; ch1 message completes before ch0 is granted.
//  5. rst_n low for 1 cycle at beat 2 of a message
//     -> next cycle all outputs 0, state IDLE, rr_ptr 0; the next grant restarts with enc_sof.
//  6. MSG_BEATS=1 with ch0 and ch3 alternating valid
//     -> every output beat has sof = eof = 1; grants alternate; random-stall scoreboard matches.

Source files
------------

// File: rtl/enc_stream_arbiter_if.sv
// Beat handshake bundle between the upstream channels, the stream arbiter
// and the RS encoder input.
`timescale 1ns/1ps
interface enc_stream_arbiter_if #(
    parameter int NUM_CH      = 4,
    parameter int ENC_SYM_NUM = 8,
    parameter int EGF_ORDER   = 8
);
    localparam int W    = ENC_SYM_NUM * EGF_ORDER;
    localparam int CH_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0]   ch_valid;
    logic [NUM_CH-1:0]   ch_ready;
    logic [NUM_CH*W-1:0] ch_data;
    logic                enc_stall;
    logic                enc_valid;
    logic [W-1:0]        enc_data;
    logic                enc_sof;
    logic                enc_eof;
    logic [CH_W-1:0]     enc_ch;

    // master: the channels plus the encoder around the arbiter; slave: the arbiter
    modport master (
        output ch_valid, ch_data, enc_stall,
        input  ch_ready, enc_valid, enc_data, enc_sof, enc_eof, enc_ch
    );

    modport slave (
        input  ch_valid, ch_data, enc_stall,
        output ch_ready, enc_valid, enc_data, enc_sof, enc_eof, enc_ch
    );
endinterface

// File: rtl/enc_stream_arbiter.sv
// Message-granular round-robin arbiter sharing one RS encoder input between
// NUM_CH streams, with a one-entry registered output stage honouring enc_stall.
`timescale 1ns/1ps
module enc_stream_arbiter #(
    parameter int NUM_CH      = 4,
    parameter int ENC_SYM_NUM = 8,
    parameter int EGF_ORDER   = 8,
    parameter int MSG_BEATS   = 28
) (
    input  logic                 clk,
    input  logic                 rst_n,
    enc_stream_arbiter_if.slave  bus,
    output logic                 busy
);
    // state | meaning
    // IDLE  | no owner; pick next channel round-robin from rr_ptr, ch_ready all 0
    // BURST | grant_q owns the encoder until MSG_BEATS beats have been accepted

    localparam int W     = ENC_SYM_NUM * EGF_ORDER;
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int CNT_W = (MSG_BEATS > 1) ? $clog2(MSG_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MSG_BEATS - 1);
    localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NUM_CH - 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t           state_q, state_d;
    logic [CH_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]  grant_q, grant_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             enc_valid_q, enc_valid_d;
    logic [W-1:0]     enc_data_q, enc_data_d;
    logic             enc_sof_q, enc_sof_d;
    logic             enc_eof_q, enc_eof_d;
    logic [CH_W-1:0]  enc_ch_q, enc_ch_d;

    logic             found;
    logic [CH_W-1:0]  pick;
    logic [CH_W-1:0]  idx;
    logic             slot_free;
    logic             accept;

    always_comb begin
        found = 1'b0;
        pick  = rr_ptr_q;
        idx   = rr_ptr_q;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = CH_W'((int'(rr_ptr_q) + i) % NUM_CH);
            if (!found && bus.ch_valid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // A new beat may enter only when the output register is empty or draining.
    assign slot_free = !enc_valid_q || !bus.enc_stall;
    assign accept    = (state_q == BURST) && bus.ch_valid[grant_q] && slot_free;

    always_comb begin
        bus.ch_ready = '0;
        if (state_q == BURST) bus.ch_ready[grant_q] = slot_free;
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        beat_cnt_d  = beat_cnt_q;
        enc_valid_d = enc_valid_q;
        enc_data_d  = enc_data_q;
        enc_sof_d   = enc_sof_q;
        enc_eof_d   = enc_eof_q;
        enc_ch_d    = enc_ch_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d    = pick;
                    beat_cnt_d = '0;
                    state_d    = BURST;
                end
            end
            BURST: begin
                if (accept && (beat_cnt_q == LAST_BEAT)) begin
                    state_d    = IDLE;
                    beat_cnt_d = '0;
                    rr_ptr_d   = (grant_q == LAST_CH) ? '0 : grant_q + 1'b1;
                end else if (accept) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            enc_valid_d = 1'b1;
            enc_data_d  = bus.ch_data[grant_q*W +: W];
            enc_ch_d    = grant_q;
            enc_sof_d   = (beat_cnt_q == '0);
            enc_eof_d   = (beat_cnt_q == LAST_BEAT);
        end else if (enc_valid_q && !bus.enc_stall) begin
            enc_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            beat_cnt_q  <= '0;
            enc_valid_q <= 1'b0;
            enc_data_q  <= '0;
            enc_sof_q   <= 1'b0;
            enc_eof_q   <= 1'b0;
            enc_ch_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            beat_cnt_q  <= beat_cnt_d;
            enc_valid_q <= enc_valid_d;
            enc_data_q  <= enc_data_d;
            enc_sof_q   <= enc_sof_d;
            enc_eof_q   <= enc_eof_d;
            enc_ch_q    <= enc_ch_d;
        end
    end

    assign bus.enc_valid = enc_valid_q;
    assign bus.enc_data  = enc_data_q;
    assign bus.enc_sof   = enc_sof_q;
    assign bus.enc_eof   = enc_eof_q;
    assign bus.enc_ch    = enc_ch_q;
    assign busy          = (state_q == BURST);
endmodule

// File: tb/tb_enc_stream_arbiter.sv
// Bench for enc_stream_arbiter: a MSG_BEATS=4 instance and a MSG_BEATS=1 instance
// share one set of stimulus variables, steered by sel.
`timescale 1ns/1ps
module tb_enc_stream_arbiter;
    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel   = 1'b0;
    logic [3:0]  tv    = '0;
    logic [63:0] td [4];
    logic        ts    = 1'b0;
    int          pass_cnt = 0;
    int          chk_cnt  = 0;

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  ch;
        logic        sof;
        logic        eof;
    } beat_t;

    always #5 clk = ~clk;

    enc_stream_arbiter_if #(.NUM_CH(4), .ENC_SYM_NUM(8), .EGF_ORDER(8)) if4 ();
    enc_stream_arbiter_if #(.NUM_CH(4), .ENC_SYM_NUM(8), .EGF_ORDER(8)) if1 ();
    logic busy4, busy1;

    enc_stream_arbiter #(.NUM_CH(4), .ENC_SYM_NUM(8), .EGF_ORDER(8), .MSG_BEATS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(if4), .busy(busy4));
    enc_stream_arbiter #(.NUM_CH(4), .ENC_SYM_NUM(8), .EGF_ORDER(8), .MSG_BEATS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1), .busy(busy1));

    wire [255:0] td_flat = {td[3], td[2], td[1], td[0]};
    assign if4.ch_valid  = sel ? 4'b0 : tv;
    assign if4.ch_data   = sel ? 256'b0 : td_flat;
    assign if4.enc_stall = sel ? 1'b0 : ts;
    assign if1.ch_valid  = sel ? tv : 4'b0;
    assign if1.ch_data   = sel ? td_flat : 256'b0;
    assign if1.enc_stall = sel ? ts : 1'b0;

    wire [3:0]  m_ready = sel ? if1.ch_ready  : if4.ch_ready;
    wire        m_valid = sel ? if1.enc_valid : if4.enc_valid;
    wire [63:0] m_data  = sel ? if1.enc_data  : if4.enc_data;
    wire        m_sof   = sel ? if1.enc_sof   : if4.enc_sof;
    wire        m_eof   = sel ? if1.enc_eof   : if4.enc_eof;
    wire [1:0]  m_ch    = sel ? if1.enc_ch    : if4.enc_ch;
    wire        m_busy  = sel ? busy1 : busy4;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; tv = '0; ts = 1'b0;
        for (int c = 0; c < 4; c++) td[c] = '0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        sel = 1'b0; rst_n = 1'b0; ts = 1'b0; tv = 4'hF;
        for (int c = 0; c < 4; c++) td[c] = {$urandom, $urandom};
        tick(); tick();
        @(negedge clk);
        chk_cnt++; if (m_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", m_valid); else pass_cnt++;
        chk_cnt++; if (m_sof !== 1'b0) $display("FAIL reset_sof: got %b want 0", m_sof); else pass_cnt++;
        chk_cnt++; if (m_eof !== 1'b0) $display("FAIL reset_eof: got %b want 0", m_eof); else pass_cnt++;
        chk_cnt++; if (m_ch !== 2'd0) $display("FAIL reset_ch: got %0d want 0", m_ch); else pass_cnt++;
        chk_cnt++; if (m_data !== 64'd0) $display("FAIL reset_data: got %h want 0", m_data); else pass_cnt++;
        chk_cnt++; if (m_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", m_busy); else pass_cnt++;
        chk_cnt++; if (m_ready !== 4'b0) $display("FAIL reset_ready: got %b want 0000", m_ready); else pass_cnt++;
        chk_cnt++; if (dut4.rr_ptr_q !== 2'd0) $display("FAIL reset_rr: got %0d want 0", dut4.rr_ptr_q); else pass_cnt++;
    endtask

    task automatic test_single();
        int  sent, nval, first, last;
        bit  acc;
        sel = 1'b0; do_reset();
        sent = 0; nval = 0; first = -1; last = -1;
        tv = 4'b0100; td[2] = 64'(sent);
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                chk_cnt++; if (m_busy !== 1'b0) $display("FAIL single_busy_pre: got %b want 0", m_busy); else pass_cnt++;
            end
            if (cyc == 1) begin
                chk_cnt++; if (m_busy !== 1'b1) $display("FAIL single_busy_post: got %b want 1", m_busy); else pass_cnt++;
            end
            acc = tv[2] && m_ready[2];
            if (m_valid) begin
                chk_cnt++;
                if ({m_data, m_ch, m_sof, m_eof} !== {64'(nval), 2'd2, nval == 0, nval == 3})
                    $display("FAIL single_beat%0d: got %h/%0d/%b/%b want %h/2/%b/%b",
                             nval, m_data, m_ch, m_sof, m_eof, 64'(nval), nval == 0, nval == 3);
                else pass_cnt++;
                if (first < 0) first = cyc;
                last = cyc;
                nval++;
            end
            tick();
            if (acc) sent++;
            if (sent >= 4) tv = '0;
            td[2] = 64'(sent);
        end
        chk_cnt++; if (nval != 4) $display("FAIL single_count: got %0d want 4", nval); else pass_cnt++;
        chk_cnt++; if (last - first != 3) $display("FAIL single_contig: got span %0d want 3", last - first); else pass_cnt++;
        chk_cnt++; if (dut4.rr_ptr_q !== 2'd3) $display("FAIL single_rr: got %0d want 3", dut4.rr_ptr_q); else pass_cnt++;
    endtask

    task automatic test_all_rr();
        int cnt [4];
        int exp_order [5];
        int sof_ch [$];
        int last_eof;
        bit [3:0] acc;
        exp_order = '{0, 1, 2, 3, 0};
        sel = 1'b0; do_reset();
        last_eof = -1;
        for (int c = 0; c < 4; c++) begin cnt[c] = 0; td[c] = {32'(c), 32'(0)}; end
        tv = 4'hF;
        for (int cyc = 0; cyc < 60 && sof_ch.size() < 5; cyc++) begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) acc[c] = tv[c] && m_ready[c];
            if (m_valid && m_sof) begin
                sof_ch.push_back(int'(m_ch));
                if (last_eof >= 0) begin
                    chk_cnt++;
                    if (cyc - last_eof != 2) $display("FAIL rr_gap: got %0d cycles eof->sof want 2", cyc - last_eof);
                    else pass_cnt++;
                end
            end
            if (m_valid && m_eof) last_eof = cyc;
            tick();
            for (int c = 0; c < 4; c++) begin
                if (acc[c]) cnt[c]++;
                td[c] = {32'(c), 32'(cnt[c])};
            end
        end
        chk_cnt++; if (sof_ch.size() != 5) $display("FAIL rr_msgs: got %0d messages want 5", sof_ch.size()); else pass_cnt++;
        for (int j = 0; j < sof_ch.size() && j < 5; j++) begin
            chk_cnt++;
            if (sof_ch[j] != exp_order[j]) $display("FAIL rr_order%0d: got ch%0d want ch%0d", j, sof_ch[j], exp_order[j]);
            else pass_cnt++;
        end
    endtask

    task automatic test_stall();
        logic [63:0] msg [4];
        logic [67:0] snap;
        int  sent, k;
        bit  acc;
        sel = 1'b0; do_reset();
        for (int i = 0; i < 4; i++) msg[i] = {$urandom, $urandom};
        sent = 0; k = 0; snap = '0;
        tv = 4'b0010; td[1] = msg[0];
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (cyc >= 3 && cyc <= 5) begin
                chk_cnt++; if (m_valid !== 1'b1) $display("FAIL stall_valid%0d: got %b want 1", cyc, m_valid); else pass_cnt++;
                chk_cnt++; if (m_ready[1] !== 1'b0) $display("FAIL stall_ready%0d: got %b want 0", cyc, m_ready[1]); else pass_cnt++;
                if (cyc == 3) snap = {m_data, m_ch, m_sof, m_eof};
                else begin
                    chk_cnt++;
                    if ({m_data, m_ch, m_sof, m_eof} !== snap)
                        $display("FAIL stall_frozen%0d: got %h want %h", cyc, {m_data, m_ch, m_sof, m_eof}, snap);
                    else pass_cnt++;
                end
            end
            if (m_valid && !ts) begin
                chk_cnt++;
                if (k >= 4) $display("FAIL stall_extra: got beat %h want none", m_data);
                else if ({m_data, m_ch, m_sof, m_eof} !== {msg[k], 2'd1, k == 0, k == 3})
                    $display("FAIL stall_beat%0d: got %h/%0d/%b/%b want %h/1/%b/%b",
                             k, m_data, m_ch, m_sof, m_eof, msg[k], k == 0, k == 3);
                else pass_cnt++;
                k++;
            end
            acc = tv[1] && m_ready[1];
            tick();
            if (acc) sent++;
            tv    = (sent < 4) ? 4'b0010 : 4'b0000;
            td[1] = (sent < 4) ? msg[sent] : 64'd0;
            ts    = (cyc + 1 >= 3) && (cyc + 1 <= 5);
        end
        chk_cnt++; if (k != 4) $display("FAIL stall_count: got %0d beats want 4", k); else pass_cnt++;
    endtask

    task automatic test_drop();
        int    sent [4];
        int    drop, ech, eidx;
        beat_t rq [$];
        int    rc [$];
        beat_t e;
        bit [3:0] acc;
        sel = 1'b0; do_reset();
        drop = 0;
        for (int c = 0; c < 4; c++) begin sent[c] = 0; td[c] = {32'(c), 32'(0)}; end
        tv = 4'b0011;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (drop > 0) begin
                chk_cnt++; if (m_busy !== 1'b1) $display("FAIL drop_busy: got %b want 1", m_busy); else pass_cnt++;
                chk_cnt++; if (m_ready[0] !== 1'b0) $display("FAIL drop_ready0: got %b want 0", m_ready[0]); else pass_cnt++;
            end
            for (int c = 0; c < 4; c++) acc[c] = tv[c] && m_ready[c];
            if (m_valid) begin
                e.data = m_data; e.ch = m_ch; e.sof = m_sof; e.eof = m_eof;
                rq.push_back(e); rc.push_back(cyc);
            end
            tick();
            for (int c = 0; c < 4; c++) if (acc[c]) sent[c]++;
            if (drop > 0) drop--;
            if (acc[1] && sent[1] == 2) drop = 2;
            tv[0] = sent[0] < 8;
            tv[1] = (sent[1] < 4) && (drop == 0);
            for (int c = 0; c < 4; c++) td[c] = {32'(c), 32'(sent[c])};
        end
        chk_cnt++; if (rq.size() != 12) $display("FAIL drop_count: got %0d beats want 12", rq.size()); else pass_cnt++;
        for (int j = 0; j < rq.size() && j < 12; j++) begin
            ech  = (j >= 4 && j < 8) ? 1 : 0;
            eidx = (j < 4) ? j : j - 4;
            e.data = {32'(ech), 32'(eidx)}; e.ch = 2'(ech); e.sof = (j % 4 == 0); e.eof = (j % 4 == 3);
            chk_cnt++;
            if (rq[j] !== e) $display("FAIL drop_beat%0d: got %h want %h", j, rq[j], e);
            else pass_cnt++;
        end
        if (rc.size() >= 7) begin
            chk_cnt++;
            if (rc[6] - rc[5] != 3) $display("FAIL drop_gap: got %0d cycles beat1->beat2 want 3", rc[6] - rc[5]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        int sent;
        bit seen, got, acc;
        sel = 1'b0; do_reset();
        sent = 0; seen = 1'b0; got = 1'b0;
        tv = 4'b0100; td[2] = '0;
        for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
            @(negedge clk);
            acc = tv[2] && m_ready[2];
            if (m_valid && m_data == 64'd2) seen = 1'b1;
            tick();
            if (acc) sent++;
            td[2] = 64'(sent);
        end
        chk_cnt++; if (!seen) $display("FAIL rmid_reach: got no beat 2 want beat 2 within 20 cycles"); else pass_cnt++;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; sent = 0; td[2] = '0;
        @(negedge clk);
        chk_cnt++; if (m_valid !== 1'b0) $display("FAIL rmid_valid: got %b want 0", m_valid); else pass_cnt++;
        chk_cnt++; if ({m_sof, m_eof} !== 2'b00) $display("FAIL rmid_sofeof: got %b want 00", {m_sof, m_eof}); else pass_cnt++;
        chk_cnt++; if (m_ch !== 2'd0) $display("FAIL rmid_ch: got %0d want 0", m_ch); else pass_cnt++;
        chk_cnt++; if (m_data !== 64'd0) $display("FAIL rmid_data: got %h want 0", m_data); else pass_cnt++;
        chk_cnt++; if (m_busy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", m_busy); else pass_cnt++;
        chk_cnt++; if (m_ready !== 4'b0) $display("FAIL rmid_ready: got %b want 0000", m_ready); else pass_cnt++;
        chk_cnt++; if (dut4.rr_ptr_q !== 2'd0) $display("FAIL rmid_rr: got %0d want 0", dut4.rr_ptr_q); else pass_cnt++;
        for (int cyc = 0; cyc < 10 && !got; cyc++) begin
            if (cyc > 0) @(negedge clk);
            acc = tv[2] && m_ready[2];
            if (m_valid) begin
                got = 1'b1;
                chk_cnt++;
                if ({m_sof, m_ch, m_data} !== {1'b1, 2'd2, 64'd0})
                    $display("FAIL rmid_restart: got sof%b ch%0d %h want sof1 ch2 0", m_sof, m_ch, m_data);
                else pass_cnt++;
            end
            tick();
            if (acc) sent++;
            td[2] = 64'(sent);
        end
        chk_cnt++; if (!got) $display("FAIL rmid_timeout: got no beat want restart beat"); else pass_cnt++;
    endtask

    // Random sources and stall against a message-level round-robin reference.
    task automatic run_scoreboard(input string name, input bit use1, input int mb,
                                  input logic [3:0] mask, input int lo, input int hi);
        logic [63:0] src [4][32];
        int    nb [4], ptr [4], nm [4], mi [4];
        beat_t expq [$];
        beat_t e;
        int    p, g, left, ei, idle;
        bit    hold;
        bit [3:0] acc;
        logic [68:0] snap;
        sel = use1; do_reset();
        left = 0;
        for (int c = 0; c < 4; c++) begin
            nm[c] = mask[c] ? int'($urandom_range(hi, lo)) : 0;
            nb[c] = nm[c] * mb; ptr[c] = 0; mi[c] = 0;
            left += nm[c];
            for (int b = 0; b < nb[c]; b++) src[c][b] = {$urandom, $urandom};
        end
        p = 0;
        while (left > 0) begin
            g = -1;
            for (int i = 0; i < 4; i++) if (g < 0 && nm[(p + i) % 4] > mi[(p + i) % 4]) g = (p + i) % 4;
            for (int b = 0; b < mb; b++) begin
                e.data = src[g][mi[g] * mb + b]; e.ch = 2'(g); e.sof = (b == 0); e.eof = (b == mb - 1);
                expq.push_back(e);
            end
            mi[g]++; left--; p = (g + 1) % 4;
        end
        for (int c = 0; c < 4; c++) begin
            tv[c] = ptr[c] < nb[c];
            td[c] = (ptr[c] < nb[c]) ? src[c][ptr[c]] : 64'd0;
        end
        ei = 0; idle = 0; hold = 1'b0; snap = '0;
        for (int cyc = 0; cyc < 2000 && idle < 12; cyc++) begin
            @(negedge clk);
            if (hold) begin
                chk_cnt++;
                if ({m_valid, m_data, m_ch, m_sof, m_eof} !== snap)
                    $display("FAIL %s_hold: got %h want %h", name, {m_valid, m_data, m_ch, m_sof, m_eof}, snap);
                else pass_cnt++;
            end
            hold = m_valid && ts;
            snap = {m_valid, m_data, m_ch, m_sof, m_eof};
            if (m_valid && !ts) begin
                chk_cnt++;
                if (ei >= expq.size()) $display("FAIL %s_extra: got beat ch%0d %h want none", name, m_ch, m_data);
                else if ({m_data, m_ch, m_sof, m_eof} !== expq[ei])
                    $display("FAIL %s_beat%0d: got %h want %h", name, ei, {m_data, m_ch, m_sof, m_eof}, expq[ei]);
                else pass_cnt++;
                ei++;
            end
            for (int c = 0; c < 4; c++) acc[c] = tv[c] && m_ready[c];
            if (ei >= expq.size()) idle++;
            tick();
            for (int c = 0; c < 4; c++) begin
                if (acc[c]) ptr[c]++;
                tv[c] = ptr[c] < nb[c];
                td[c] = (ptr[c] < nb[c]) ? src[c][ptr[c]] : 64'd0;
            end
            ts = ($urandom_range(3, 0) == 0);
        end
        chk_cnt++;
        if (ei != expq.size()) $display("FAIL %s_count: got %0d beats want %0d", name, ei, expq.size());
        else pass_cnt++;
        ts = 1'b0;
    endtask

    task automatic test_random_4ch();
        run_scoreboard("rand4", 1'b0, 4, 4'b1111, 1, 4);
    endtask

    task automatic test_mb1();
        run_scoreboard("mb1", 1'b1, 1, 4'b1001, 3, 8);
    endtask

    initial begin
        for (int c = 0; c < 4; c++) td[c] = '0;
        test_reset();
        test_single();
        test_all_rr();
        test_stall();
        test_drop();
        test_reset_mid();
        test_random_4ch();
        test_mb1();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
